// File: rtl/pc_next_unit.sv
// Fetch-side PC register and next-PC selection: sequential, branch, jump,
// register jump, exception entry and ERET return, plus fetch fault and taken-branch count.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_4000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic [31:0]      epc,
    input  logic [31:0]      d_pc,
    input  logic [2:0]       npc_op,
    input  logic [2:0]       br_type,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic [25:0]      imm26,
    output logic [31:0]      f_pc,
    output logic [31:0]      npc,
    output logic             br_taken,
    output logic             f_exc_adel,
    output logic [CNT_W-1:0] br_cnt
);

    typedef enum logic [2:0] {
        OP_PC4 = 3'd0,
        OP_BR  = 3'd1,
        OP_J   = 3'd2,
        OP_JR  = 3'd3
    } npc_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLEZ = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_BGEZ = 3'd5
    } br_type_e;

    logic [31:0]      f_pc_q, f_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

    logic [31:0] seq_target;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        br_cond;
    logic        rs_neg;
    logic        rs_zero;
    logic        cnt_inc;

    assign seq_target = f_pc_q + 32'd4;
    assign br_target  = d_pc + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign j_target   = {d_pc[31:28], imm26, 2'b00};

    assign rs_neg  = rs_data[31];
    assign rs_zero = (rs_data == 32'd0);

    // NOTE: every signal driven in an always_comb gets a default on entry so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BR_BEQ:  br_cond = (rs_data == rt_data);
            BR_BNE:  br_cond = (rs_data != rt_data);
            BR_BLEZ: br_cond = rs_neg | rs_zero;
            BR_BGTZ: br_cond = ~rs_neg & ~rs_zero;
            BR_BLTZ: br_cond = rs_neg;
            BR_BGEZ: br_cond = ~rs_neg;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken = (npc_op == OP_BR) && br_cond;

    // Redirects from CP0 outrank stall; req wins over eret when both are up.
    always_comb begin
        npc = seq_target;
        if (reset) begin
            npc = RESET_PC;
        end else if (req) begin
            npc = EXC_ENTRY;
        end else if (eret) begin
            npc = epc;
        end else if (stall) begin
            npc = f_pc_q;
        end else begin
            case (npc_op)
                OP_BR:   npc = br_taken ? br_target : seq_target;
                OP_J:    npc = j_target;
                OP_JR:   npc = rs_data;
                default: npc = seq_target;
            endcase
        end
    end

    assign cnt_inc = br_taken && !stall && !req && !eret;

    always_comb begin
        f_pc_d   = npc;
        br_cnt_d = br_cnt_q;
        if (cnt_inc && (br_cnt_q != {CNT_W{1'b1}})) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q   <= RESET_PC;
            br_cnt_q <= '0;
        end else begin
            f_pc_q   <= f_pc_d;
            br_cnt_q <= br_cnt_d;
        end
    end

    // 33-bit unsigned window bounds so BASE+BYTES cannot overflow.
    logic [32:0] pc_ext, win_lo, win_hi;
    assign pc_ext = {1'b0, f_pc_q};
    assign win_lo = {1'b0, IMEM_BASE};
    assign win_hi = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    assign f_exc_adel = (f_pc_q[1:0] != 2'b00) || (pc_ext < win_lo) || (pc_ext >= win_hi);

    assign f_pc   = f_pc_q;
    assign br_cnt = br_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios then randomized
// stimulus against a behavioural model; a second instance checks CNT_W=2 saturation.
module tb_pc_next_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY  = 32'h0000_4180;
    localparam longint      IMEM_BASE  = 64'h0000_3000;
    localparam longint      IMEM_BYTES = 64'h0000_4000;

    logic        clk;
    logic        reset, stall, req, eret;
    logic [31:0] epc, d_pc, rs_data, rt_data;
    logic [2:0]  npc_op, br_type;
    logic [25:0] imm26;

    logic [31:0] f_pc, npc;
    logic        br_taken, f_exc_adel;
    logic [15:0] br_cnt;

    logic [31:0] f_pc2, npc2;
    logic        br_taken2, f_exc_adel2;
    logic [1:0]  br_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    int          m_cnt, m_cnt2;

    pc_next_unit u_dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
        .epc(epc), .d_pc(d_pc), .npc_op(npc_op), .br_type(br_type),
        .rs_data(rs_data), .rt_data(rt_data), .imm26(imm26),
        .f_pc(f_pc), .npc(npc), .br_taken(br_taken),
        .f_exc_adel(f_exc_adel), .br_cnt(br_cnt)
    );

    pc_next_unit #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
        .epc(epc), .d_pc(d_pc), .npc_op(npc_op), .br_type(br_type),
        .rs_data(rs_data), .rt_data(rt_data), .imm26(imm26),
        .f_pc(f_pc2), .npc(npc2), .br_taken(br_taken2),
        .f_exc_adel(f_exc_adel2), .br_cnt(br_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] bt, input logic [31:0] rs, input logic [31:0] rt);
        case (bt)
            3'd0:    return rs == rt;
            3'd1:    return rs != rt;
            3'd2:    return $signed(rs) <= 0;
            3'd3:    return $signed(rs) > 0;
            3'd4:    return $signed(rs) < 0;
            3'd5:    return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_adel(input logic [31:0] pc);
        longint p = longint'(pc);
        return (pc % 4 != 0) || (p < IMEM_BASE) || (p >= IMEM_BASE + IMEM_BYTES);
    endfunction

    function automatic logic [31:0] sext_word_offset(input logic [15:0] imm);
        int off = int'($signed(imm)) * 4;
        return 32'(off);
    endfunction

    task automatic set_idle();
        reset = 0; stall = 0; req = 0; eret = 0;
        npc_op = 3'd0; br_type = 3'd0;
        epc = 32'h0; d_pc = 32'h0000_3000; rs_data = 32'h0; rt_data = 32'h0;
        imm26 = 26'h0;
    endtask

    // One clock: check combinational outputs, take the edge, advance the model, check state.
    task automatic do_cycle();
        logic        e_tk;
        logic [31:0] e_npc;
        e_tk = (npc_op == 3'd1) && ref_cond(br_type, rs_data, rt_data);
        if (reset)      e_npc = RESET_PC;
        else if (req)   e_npc = EXC_ENTRY;
        else if (eret)  e_npc = epc;
        else if (stall) e_npc = m_pc;
        else if (npc_op == 3'd1 && e_tk)
            e_npc = d_pc + 32'd4 + sext_word_offset(imm26[15:0]);
        else if (npc_op == 3'd2)
            e_npc = {d_pc[31:28], imm26, 2'b00};
        else if (npc_op == 3'd3)
            e_npc = rs_data;
        else
            e_npc = m_pc + 32'd4;
        #1;
        check("npc", npc, e_npc);
        check("br_taken", 32'(br_taken), 32'(e_tk));
        check("f_exc_adel", 32'(f_exc_adel), 32'(ref_adel(m_pc)));
        @(posedge clk);
        if (reset) begin
            m_pc = RESET_PC; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_pc = e_npc;
            if (e_tk && !stall && !req && !eret) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
        check("f_pc", f_pc, m_pc);
        check("br_cnt", 32'(br_cnt), 32'(m_cnt));
        check("br_cnt_w2", 32'(br_cnt2), 32'(m_cnt2));
        @(negedge clk);
    endtask

    task automatic set_branch(input logic [2:0] bt, input logic [31:0] rs, input logic [31:0] rt);
        npc_op = 3'd1; br_type = bt; rs_data = rs; rt_data = rt;
        d_pc = 32'h0000_3004; imm26 = 26'h000_FFFF;
    endtask

    initial begin
        int exp_c2 [5];
        exp_c2 = '{1, 2, 3, 3, 3};

        set_idle();
        reset = 1;
        @(posedge clk);
        #1;
        m_pc = RESET_PC; m_cnt = 0; m_cnt2 = 0;
        @(negedge clk);
        reset = 0;
        check("reset_f_pc", f_pc, 32'h0000_3000);
        check("reset_br_cnt", 32'(br_cnt), 32'd0);
        check("reset_adel", 32'(f_exc_adel), 32'd0);

        repeat (3) do_cycle();
        check("free_run_pc", f_pc, 32'h0000_300C);

        // BEQ taken back to d_pc (offset -4), then not taken.
        set_branch(3'd0, 32'd5, 32'd5);
        do_cycle();
        check("beq_taken_pc", f_pc, 32'h0000_3004);
        check("beq_taken_cnt", 32'(br_cnt), 32'd1);
        rs_data = 32'd6;
        do_cycle();
        check("beq_not_taken_pc", f_pc, 32'h0000_3008);
        check("beq_not_taken_cnt", 32'(br_cnt), 32'd1);

        set_branch(3'd2, 32'h8000_0000, 32'h0);
        #1 check("blez_neg", 32'(br_taken), 32'd1);
        do_cycle();
        set_branch(3'd3, 32'h0, 32'h0);
        #1 check("bgtz_zero", 32'(br_taken), 32'd0);
        do_cycle();
        set_branch(3'd5, 32'h0, 32'h1);
        #1 check("bgez_zero", 32'(br_taken), 32'd1);
        do_cycle();
        set_branch(3'd7, 32'h5, 32'h5);
        #1 check("br_type7", 32'(br_taken), 32'd0);
        do_cycle();

        // Stall with a pending jump, then redirects through the stall.
        set_idle();
        npc_op = 3'd2; imm26 = 26'h000_0C40; stall = 1;
        repeat (3) do_cycle();
        req = 1;
        do_cycle();
        check("req_in_stall", f_pc, 32'h0000_4180);
        eret = 1; epc = 32'h0000_3010;
        do_cycle();
        check("eret_req", f_pc, 32'h0000_4180);
        req = 0;
        do_cycle();
        check("eret_alone", f_pc, 32'h0000_3010);
        set_idle();

        npc_op = 3'd3; rs_data = 32'h0000_3002;
        do_cycle();
        check("jr_misaligned_pc", f_pc, 32'h0000_3002);
        check("jr_misaligned_adel", 32'(f_exc_adel), 32'd1);
        rs_data = 32'h0000_7000;
        do_cycle();
        check("jr_above_adel", 32'(f_exc_adel), 32'd1);
        rs_data = 32'h0000_6FFC;
        do_cycle();
        check("jr_top_adel", 32'(f_exc_adel), 32'd0);

        // Narrow counter saturation.
        set_idle();
        reset = 1;
        do_cycle();
        reset = 0;
        set_branch(3'd0, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            check("cnt_w2_sat", 32'(br_cnt2), 32'(exp_c2[i]));
        end

        reset = 1; stall = 1; req = 1;
        do_cycle();
        check("reset_over_req_pc", f_pc, 32'h0000_3000);
        check("reset_over_req_cnt", 32'(br_cnt), 32'd0);
        set_idle();

        for (int i = 0; i < 2000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            req     = ($urandom_range(0, 19) == 0);
            eret    = ($urandom_range(0, 19) == 0);
            npc_op  = 3'($urandom_range(0, 7));
            br_type = 3'($urandom_range(0, 7));
            rt_data = $urandom;
            case ($urandom_range(0, 3))
                0:       rs_data = $urandom;
                1:       rs_data = 32'h0;
                2:       rs_data = 32'h8000_0000;
                default: rs_data = rt_data;
            endcase
            if ($urandom_range(0, 3) != 0 && npc_op == 3'd3)
                rs_data = 32'h0000_3000 + 32'($urandom_range(0, 32'h4000));
            d_pc  = 32'h0000_3000 + 32'($urandom_range(0, 32'h3FFC));
            imm26 = 26'($urandom);
            epc   = ($urandom_range(0, 1) == 0) ? 32'h0000_3000 + 32'($urandom_range(0, 32'h3FFC)) : $urandom;
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
